// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream frame arbiter.
// Holds the FSM state type, source count and counter sizing.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int NUM_SRC = 2;

    function automatic int cnt_width(input int frame_len);
        return (frame_len < 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_pick2.sv
// Two-way round-robin pick.
// On a tie the source other than the last grant wins.
module rr_pick2
    import axis_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic               last,
    output logic               gnt_idx,
    output logic               gnt_valid
);

    // Tie goes to the source not served last; otherwise the lone requester.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one AXIS sink between two sources.
// Optional per-source frame counters: define AXIS_FRAME_ARB_STATS_EN.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_FRAME_LEN  = 16,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic                    i_enable,
    output logic                    s_axis_0_tready,
    input  logic                    s_axis_0_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_0_tdata,
    output logic                    s_axis_1_tready,
    input  logic                    s_axis_1_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_1_tdata,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tid,
    output logic                    m_axis_sof,
    output logic                    o_busy
`ifdef AXIS_FRAME_ARB_STATS_EN
    ,
    output logic [C_CNT_WIDTH-1:0]  o_frames_0,
    output logic [C_CNT_WIDTH-1:0]  o_frames_1
`endif
);

    localparam int CW = cnt_width(C_FRAME_LEN);
    localparam logic [CW-1:0] LAST_W = CW'(C_FRAME_LEN - 1);

    if (C_FRAME_LEN < 2 || C_FRAME_LEN > 256 || C_CNT_WIDTH < 1) begin : g_param_check
        $error("axis_frame_arbiter: illegal parameter value");
    end

    arb_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          gnt, gnt_n;
    logic          last, last_n;
    logic          frame_done;
    logic          pick_idx;
    logic          pick_valid;

    rr_pick2 u_pick (
        .req       ({s_axis_1_tvalid, s_axis_0_tvalid}),
        .last      (last),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    // State, word counter, grant and last-grant pointer registers.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            last  <= last_n;
        end
    end

    // Arbitrate in IDLE; pass the granted source through in XFER.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        gnt_n           = gnt;
        last_n          = last;
        frame_done      = 1'b0;
        s_axis_0_tready = 1'b0;
        s_axis_1_tready = 1'b0;
        m_axis_tvalid   = 1'b0;
        m_axis_tdata    = '0;
        m_axis_tid      = gnt;
        m_axis_sof      = 1'b0;
        o_busy          = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_enable && pick_valid) begin
                    gnt_n   = pick_idx;
                    state_n = XFER;
                end
            end
            XFER: begin
                o_busy          = 1'b1;
                m_axis_tvalid   = gnt ? s_axis_1_tvalid : s_axis_0_tvalid;
                m_axis_tdata    = gnt ? s_axis_1_tdata : s_axis_0_tdata;
                s_axis_0_tready = ~gnt & m_axis_tready;
                s_axis_1_tready = gnt & m_axis_tready;
                m_axis_sof      = (cnt == '0) & m_axis_tvalid;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (cnt == LAST_W) begin
                        cnt_n      = '0;
                        last_n     = gnt;
                        state_n    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AXIS_FRAME_ARB_STATS_EN
    // Completed-frame counters per source, wrapping naturally.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            o_frames_0 <= '0;
            o_frames_1 <= '0;
        end else if (frame_done) begin
            if (gnt) begin
                o_frames_1 <= o_frames_1 + C_CNT_WIDTH'(1);
            end else begin
                o_frames_0 <= o_frames_0 + C_CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
`endif

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Frame-level round-robin arbiter: shares the single ChaCha20 transmitter AXI-Stream input between two plaintext sources.
- Grant is held for exactly one ChaCha20 block (C_FRAME_LEN 32-bit words), so keystream blocks are never interleaved between sources.
- Sits between the plaintext producers and the transmitter's s_axis input. Emits start-of-frame and source-ID sideband signals for the downstream framing logic.

Parameters:
- C_DATA_WIDTH, 32, stream data width in bits.
- C_FRAME_LEN, 16, words per frame (one 512-bit ChaCha20 block); legal range 2..256.
- C_CNT_WIDTH, 32, width of the optional statistics counters.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  asynchronous reset, active-high.
- i_enable  in  1  arbitration enable; sampled only in IDLE.
- s_axis_0_tready  out  1  source 0 ready.
- s_axis_0_tvalid  in  1  source 0 valid.
- s_axis_0_tdata  in  C_DATA_WIDTH  source 0 data.
- s_axis_1_tready  out  1  source 1 ready.
- s_axis_1_tvalid  in  1  source 1 valid.
- s_axis_1_tdata  in  C_DATA_WIDTH  source 1 data.
- m_axis_tready  in  1  transmitter ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  C_DATA_WIDTH  output data.
- m_axis_tid  out  1  index of the granted source.
- m_axis_sof  out  1  high with the first word of each frame.
- o_busy  out  1  high while in XFER.

Behaviour:
- Interface: one clock, s_axi_aclk. Reset s_axi_areset is asynchronous and active-high.
- Reset values:
  - All tready and m_axis_tvalid low; m_axis_tdata 0; m_axis_tid 0; m_axis_sof 0; o_busy 0.
  - State IDLE; word counter 0.
  - Last-grant pointer = 1, so source 0 wins the first tie.
- States:
  - IDLE: no tready asserted; m_axis_tvalid low.
    - If i_enable=1 and any source tvalid=1, latch the grant and go to XFER on the next edge (1-cycle arbitration latency).
    - Both valid: grant the source not equal to the last-grant pointer.
    - One valid: grant that source.
  - XFER: combinational pass-through from the granted source.
    - m_axis_tvalid = granted tvalid; m_axis_tdata = granted tdata.
    - Granted tready = m_axis_tready; the non-granted tready stays 0.
    - m_axis_tid = grant (stable for the whole frame).
    - m_axis_sof = (counter==0) & m_axis_tvalid.
- Handshake: counter increments on m_axis_tvalid & m_axis_tready. On a handshake with counter==C_FRAME_LEN-1:
  - counter clears to 0;
  - last-grant pointer updates to the current grant;
  - state returns to IDLE.
- Frame gap: re-arbitration always passes through IDLE, giving a minimum 1-cycle bubble between frames.
- Stalls: source tvalid low mid-frame, or m_axis_tready low, pauses the frame indefinitely. There is no timeout and no switching mid-frame.
- i_enable deasserted mid-frame: the current frame completes, then the block holds in IDLE.
- Non-granted source asserting tvalid: ignored. Its data is held by its own AXIS rules, since its tready is 0.
- Simultaneous frame end and new request: the request is evaluated in the following IDLE cycle using the updated pointer.
- Reset mid-frame: immediate return to reset values. The partial frame is abandoned; the downstream block is reset by the same signal.
- Counter width: $clog2(C_FRAME_LEN).

Optional Feature:
- Macro: AXIS_FRAME_ARB_STATS_EN.
- With the macro defined, the block adds two outputs, o_frames_0 and o_frames_1, each C_CNT_WIDTH wide.
  - Each counts completed frames for its source, incrementing on the final-word handshake.
  - The counters wrap modulo 2^C_CNT_WIDTH and reset to 0.
- Without the macro, neither the ports nor the registers exist.

Decomposition:
- Package axis_arb_pkg holds:
  - typedef arb_state_t {IDLE, XFER};
  - localparam NUM_SRC = 2;
  - function for counter width.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin pick from (req[1:0], last) to (gnt_idx, gnt_valid).

Test Plan:
- Only source 0 sends 32 words (0x00..0x1F), m_axis_tready=1 → two frames, tid=0, sof on words 0x00 and 0x10, one idle cycle between frames.
- Both sources valid continuously (src0 data 0xA000+n, src1 data 0xB000+n) → frames alternate tid 0,1,0,1; each frame is 16 contiguous words from one source; first frame tid=0.
- m_axis_tready toggled 1/0 every cycle during a frame → exactly 16 handshakes; tid held; non-granted tready stays 0 throughout.
- i_enable dropped after word 5 of a frame → words 6..15 still transfer; the block then stays IDLE with o_busy=0 while both sources remain valid.
- s_axi_areset pulsed after word 7 → all outputs return to 0 asynchronously. After release with both sources valid, the first grant is tid=0 and sof is set on the first word.
- AXIS_FRAME_ARB_STATS_EN defined, 3 frames src0 and 2 frames src1 → o_frames_0=3, o_frames_1=2; both counters read 0 after reset.
